div8_serial: RTL and testbench
==============================

# div8_serial

Sequential unsigned fractional divider, the inverse of the team's parallel Q0.8 multiplier. It computes q = floor(a·2^W / b) for a < b using restoring division, producing one quotient bit per clock. It sits beside the multiplier in the fixed-point datapath to normalise ratios back into Q0.W fractions. A start/busy/done handshake lets a controlling FSM issue one division at a time.

## Interface
- W, default 8: operand and quotient width (Q0.W fraction).
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request a division; sampled only when busy_o = 0.
- a_i  in  W  dividend, unsigned; captured on the accepting edge.
- b_i  in  W  divisor, unsigned; captured on the accepting edge.
- busy_o  out  1  high while a division is in progress.
- done_o  out  1  one-cycle pulse when q_o/ovf_o are updated.
- q_o  out  W  quotient, Q0.W; held stable until the next done_o.
- ovf_o  out  1  the last result was invalid (a ≥ b, including b = 0).

## Operation
- States:
  - IDLE: busy_o = 0. start_i = 1 captures a_i, b_i, clears the iteration counter and moves to CALC.
  - CALC: busy_o = 1, runs N iterations (N = W, or W+1 with rounding), then returns to IDLE.
- Registers: remainder r is W+1 bits, initialised to {0, a}. Internal quotient shift register qs, counter cnt of width ceil(log2(W+2)).
- Each iteration: t = r << 1. If t ≥ {0, b} then r ← t − b and shift 1 into qs; otherwise r ← t and shift 0 into qs.
- Overflow: flag ovf = (a ≥ b) is evaluated at capture. The iterations still run; the result becomes q_o = all ones, ovf_o = 1. Latency does not change.
- start_i while busy_o = 1 is ignored; no queueing.
- Operands are captured, so a_i and b_i may change after the accepting edge without effect.

## Timing
- Reset values: busy_o = 0, done_o = 0, q_o = 0, ovf_o = 0, state IDLE, cnt = 0, r = 0, qs = 0.
- Edge 0: start_i is sampled in IDLE, and busy_o = 1 from edge 0.
- Edges 1..N: the iterations run. At edge N, q_o and ovf_o are written, done_o = 1 for exactly one cycle, and busy_o drops to 0.
- Latency is N edges from acceptance to done_o.
- The earliest following start_i is sampled at edge N+1, giving a throughput of one result per N+1 cycles.
- Reset asserted mid-operation returns all outputs to their reset values immediately. The in-flight operation is lost and no done_o is produced.
- done_o and busy_o are never both 1.

## Configuration
- DIV8_ROUND_EN defined:
  - N = W+1; the extra iteration produces a guard bit g.
  - q_o = qs[W:1] + g, saturating at all ones.
  - Result is round-half-up; latency W+1.
- DIV8_ROUND_EN undefined:
  - N = W; q_o is the truncated quotient; latency W.

## Structure
- Shared package div8_pkg holds:
  - the state enum (IDLE, CALC);
  - the default width constant DIV_W = 8;
  - the iteration-count constant derived from DIV_W and DIV8_ROUND_EN.
- Sub-module div8_step is the combinational single restoring iteration:
  - inputs: r (W+1 bits) and b (W bits);
  - outputs: next r and the quotient bit.
- The top level holds the FSM, counter and output registers.

## Test plan
- a=1, b=3 → q_o=0x55, ovf_o=0, done_o at edge 8 (edge 9 with DIV8_ROUND_EN, q_o still 0x55).
- a=2, b=3 → q_o=0xAA truncated, 0xAB with DIV8_ROUND_EN. a=128, b=255 → 0x80 truncated, 0x81 rounded.
- a=100, b=100, then a=7, b=0 → both give q_o=0xFF, ovf_o=1, with full latency.
- start_i held high continuously with changing operands → only operands present at accepting edges are used; results arrive every N+1 cycles; busy_o and done_o never overlap.
- Assert rst at edge 4 of a division → outputs go to 0 at once, no done_o. A new start after reset yields the correct result.
- Random sweep of a < b, all 8-bit pairs → q_o matches floor(a·256/b) (or the rounded value) exactly.

Source files
------------

// File: rtl/div8_pkg.sv
// Shared types and constants for the serial Q0.W fractional divider.
// DIV8_ROUND_EN adds a guard iteration so the result is rounded half-up.
package div8_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } div8_state_t;

    localparam int DIV_W = 8;

`ifdef DIV8_ROUND_EN
    localparam bit DIV_ROUND_EN = 1'b1;
`else
    localparam bit DIV_ROUND_EN = 1'b0;
`endif

    // Number of restoring iterations for a quotient of width w.
    function automatic int div_iters(input int w);
        return DIV_ROUND_EN ? w + 1 : w;
    endfunction

    localparam int DIV_N = div_iters(DIV_W);

endpackage

// File: rtl/div8_step.sv
// One combinational restoring-division iteration: shift the remainder left,
// trial-subtract the divisor and emit the resulting quotient bit.
module div8_step
    import div8_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W:0]   r_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   r_o,
    output logic         q_o
);

    logic [W+1:0] t;
    logic [W:0]   diff;

    assign t    = {r_i, 1'b0};
    assign q_o  = (t >= {2'b00, b_i});
    // Only evaluated when t >= b and, for valid operands, t fits in W+1 bits.
    assign diff = t[W:0] - {1'b0, b_i};
    assign r_o  = q_o ? diff : t[W:0];

endmodule

// File: rtl/div8_serial.sv
// Sequential unsigned fractional divider q = floor(a*2^W/b), one bit per clock.
// Define DIV8_ROUND_EN for a round-half-up result with one extra cycle of latency.
module div8_serial
    import div8_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] q_o,
    output logic         ovf_o
);

    localparam int N  = div_iters(W);
    localparam int CW = $clog2(W + 2);

    div8_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]   r_q, r_d, r_step;
    logic [W-1:0] b_q, b_d;
    logic [N-1:0] qs_q, qs_d, qs_shift;
    logic         ovf_flag_q, ovf_flag_d;
    logic [W-1:0] q_q, q_d;
    logic         ovf_q, ovf_d;
    logic         done_q, done_d;
    logic         q_bit;
    logic [W-1:0] q_res;

    div8_step #(.W(W)) u_step (
        .r_i (r_q),
        .b_i (b_q),
        .r_o (r_step),
        .q_o (q_bit)
    );

    assign qs_shift = {qs_q[N-2:0], q_bit};

`ifdef DIV8_ROUND_EN
    logic [W:0] q_rnd;
    // Last bit is the guard bit; a carry out of the add saturates.
    assign q_rnd = {1'b0, qs_shift[W:1]} + {{W{1'b0}}, qs_shift[0]};
    assign q_res = q_rnd[W] ? '1 : q_rnd[W-1:0];
`else
    assign q_res = qs_shift[W-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        b_d        = b_q;
        qs_d       = qs_q;
        ovf_flag_d = ovf_flag_q;
        q_d        = q_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = CALC;
                    cnt_d      = '0;
                    r_d        = {1'b0, a_i};
                    b_d        = b_i;
                    qs_d       = '0;
                    ovf_flag_d = (a_i >= b_i);
                end
            end
            CALC: begin
                r_d   = r_step;
                qs_d  = qs_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    q_d     = ovf_flag_q ? '1 : q_res;
                    ovf_d   = ovf_flag_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            r_q        <= '0;
            b_q        <= '0;
            qs_q       <= '0;
            ovf_flag_q <= 1'b0;
            q_q        <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            b_q        <= b_d;
            qs_q       <= qs_d;
            ovf_flag_q <= ovf_flag_d;
            q_q        <= q_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy_o = (state_q == CALC);
    assign done_o = done_q;
    assign q_o    = q_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_div8_serial.sv
// Directed self-checking bench for div8_serial (W = 8); follows DIV8_ROUND_EN
// for latency and expected quotients.
module tb_div8_serial;

`ifdef DIV8_ROUND_EN
    localparam int N = 9;
`else
    localparam int N = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [7:0] a_i, b_i;
    logic       busy_o, done_o, ovf_o;
    logic [7:0] q_o;

    int total = 0;
    int bad   = 0;

    div8_serial dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .q_o     (q_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference quotient for a < b: truncated or round-half-up with saturation.
    function automatic logic [7:0] model_q(input int a, input int b);
        int v;
`ifdef DIV8_ROUND_EN
        v = (a * 512) / b;
        v = (v + 1) / 2;
        if (v > 255) v = 255;
`else
        v = (a * 256) / b;
`endif
        return v[7:0];
    endfunction

    // Issue one division from IDLE (called just after a clock edge).
    task automatic do_div(input string tag, input int a, input int b,
                          input logic [7:0] exp_q, input logic exp_ovf);
        int lat;
        start_i = 1'b1;
        a_i     = a[7:0];
        b_i     = b[7:0];
        @(posedge clk); #1;
        chk({tag, ".busy0"}, 32'(busy_o), 32'd1);
        start_i = 1'b0;
        a_i     = 8'hC3;
        b_i     = 8'h01;
        lat     = -1;
        for (int k = 1; k <= N + 3; k++) begin
            @(posedge clk); #1;
            if (done_o) begin
                lat = k;
                break;
            end
        end
        chk({tag, ".lat"}, 32'(lat), 32'(N));
        chk({tag, ".q"}, 32'(q_o), 32'(exp_q));
        chk({tag, ".ovf"}, 32'(ovf_o), 32'(exp_ovf));
        chk({tag, ".busy_at_done"}, 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 32'(done_o), 32'd0);
        $display("div %s a=%0d b=%0d q=0x%02h ovf=%0d latency=%0d", tag, a, b, q_o, ovf_o, lat);
    endtask

    initial begin
        int         done_seen;
        logic [7:0] exp_pipe;
        int         av, bv;

        rst     = 1'b1;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy_o), 32'd0);
        chk("rst.done", 32'(done_o), 32'd0);
        chk("rst.q",    32'(q_o),    32'd0);
        chk("rst.ovf",  32'(ovf_o),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef DIV8_ROUND_EN
        do_div("1/3",     1,   3, 8'h55, 1'b0);
        do_div("2/3",     2,   3, 8'hAB, 1'b0);
        do_div("128/255", 128, 255, 8'h81, 1'b0);
`else
        do_div("1/3",     1,   3, 8'h55, 1'b0);
        do_div("2/3",     2,   3, 8'hAA, 1'b0);
        do_div("128/255", 128, 255, 8'h80, 1'b0);
`endif
        do_div("100/100", 100, 100, 8'hFF, 1'b1);
        do_div("7/0",     7,   0, 8'hFF, 1'b1);
        do_div("1/255",   1, 255, model_q(1, 255), 1'b0);
        do_div("254/255", 254, 255, model_q(254, 255), 1'b0);

        // start_i held high with operands changing every cycle.
        exp_pipe = '0;
        start_i  = 1'b1;
        for (int c = 0; c < 3 * (N + 1); c++) begin
            av  = (c % 5) + 1;
            bv  = 200 + c;
            a_i = av[7:0];
            b_i = bv[7:0];
            @(posedge clk); #1;
            if (c % (N + 1) == 0) exp_pipe = model_q(av, bv);
            chk("stream.overlap", 32'(busy_o & done_o), 32'd0);
            chk("stream.done", 32'(done_o), 32'((c % (N + 1)) == N));
            if (c % (N + 1) == N) begin
                chk("stream.q", 32'(q_o), 32'(exp_pipe));
                $display("stream result at cycle %0d q=0x%02h", c, q_o);
            end
        end
        start_i = 1'b0;
        @(posedge clk); #1;

        // Reset during edge 4 of a division.
        start_i = 1'b1;
        a_i     = 8'd2;
        b_i     = 8'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst.busy_before", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst.busy", 32'(busy_o), 32'd0);
        chk("midrst.done", 32'(done_o), 32'd0);
        chk("midrst.q",    32'(q_o),    32'd0);
        chk("midrst.ovf",  32'(ovf_o),  32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        done_seen = 0;
        for (int k = 0; k < N + 2; k++) begin
            @(posedge clk); #1;
            if (done_o) done_seen++;
        end
        chk("midrst.no_done", 32'(done_seen), 32'd0);
        $display("reset mid-operation: done pulses after reset=%0d", done_seen);
        do_div("post_rst", 2, 3, model_q(2, 3), 1'b0);

        // Random sweep of a < b.
        for (int i = 0; i < 20; i++) begin
            bv = int'($urandom_range(255, 1));
            av = int'($urandom_range(bv - 1, 0));
            do_div("sweep", av, bv, model_q(av, bv), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
